// File: rtl/srl_fifo_ctrl.sv
// srl_fifo_ctrl
// Turns an external shift-register storage array into a first-word-fall-through
// FIFO with a full_n/empty_n handshake. New words shift in at entry 0, so the
// oldest word sits at entry count-1 and the read address tracks it.
//
// Ports:
//   clk, reset        : clock and synchronous active-high reset
//   if_full_n         : registered, 1 = space available
//   if_write_ce/if_write/if_din : write side (push when enabled and not full)
//   if_empty_n        : registered, 1 = data available
//   if_read_ce/if_read: read side (pop when enabled and not empty)
//   if_dout           : head-of-FIFO word (valid while if_empty_n = 1)
//   if_almost_full    : registered, count >= AFULL_LEVEL
//   if_count          : registered occupancy 0..DEPTH
//   err_overflow      : sticky, write attempted while full
//   err_underflow     : sticky, read attempted while empty
//   srl_we/srl_addr/srl_din/srl_dout : storage array interface
module srl_fifo_ctrl #(
  parameter int DATA_WIDTH  = 1,
  parameter int ADDR_WIDTH  = 1,
  parameter int DEPTH       = 2,
  parameter int AFULL_LEVEL = DEPTH - 1
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  if_full_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_almost_full,
  output logic [ADDR_WIDTH:0]   if_count,
  output logic                  err_overflow,
  output logic                  err_underflow,
  output logic                  srl_we,
  output logic [ADDR_WIDTH-1:0] srl_addr,
  output logic [DATA_WIDTH-1:0] srl_din,
  input  logic [DATA_WIDTH-1:0] srl_dout
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_C = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   AFULL_C = AFULL_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1'b1);
  localparam logic [ADDR_WIDTH-1:0] ADR_ONE = ADDR_WIDTH'(1'b1);

  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  full_n_q, full_n_d;
  logic                  empty_n_q, empty_n_d;
  logic                  afull_q, afull_d;
  logic                  err_ov_q, err_ov_d;
  logic                  err_un_q, err_un_d;
  logic                  push_s, pop_s;

  // Accepted transfers are gated by the registered flags, never by count_d.
  assign push_s = if_write & if_write_ce & full_n_q;
  assign pop_s  = if_read  & if_read_ce  & empty_n_q;

  assign srl_we         = push_s;
  assign srl_din        = if_din;
  assign srl_addr       = addr_q;
  assign if_dout        = srl_dout;
  assign if_full_n      = full_n_q;
  assign if_empty_n     = empty_n_q;
  assign if_almost_full = afull_q;
  assign if_count       = count_q;
  assign err_overflow   = err_ov_q;
  assign err_underflow  = err_un_q;

  // Next-state for occupancy, read pointer, flags and sticky errors.
  always_comb begin
    count_d = count_q;
    addr_d  = addr_q;
    case ({push_s, pop_s})
      2'b10: begin
        count_d = count_q + CNT_ONE;
        // First word lands at entry 0, where the pointer already is.
        if (count_q != '0) begin
          addr_d = addr_q + ADR_ONE;
        end else begin
          addr_d = '0;
        end
      end
      2'b01: begin
        count_d = count_q - CNT_ONE;
        if (count_q > CNT_ONE) begin
          addr_d = addr_q - ADR_ONE;
        end else begin
          addr_d = '0;
        end
      end
      // Simultaneous push+pop: shift moves the head up by one, pop consumes it.
      default: begin
        count_d = count_q;
        addr_d  = addr_q;
      end
    endcase
    empty_n_d = (count_d != '0);
    full_n_d  = (count_d != DEPTH_C);
    afull_d   = (count_d >= AFULL_C);
    err_ov_d  = err_ov_q | (if_write & if_write_ce & ~full_n_q);
    err_un_d  = err_un_q | (if_read  & if_read_ce  & ~empty_n_q);
  end

  // State registers with synchronous reset; storage contents are left alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      addr_q    <= '0;
      full_n_q  <= 1'b1;
      empty_n_q <= 1'b0;
      afull_q   <= 1'b0;
      err_ov_q  <= 1'b0;
      err_un_q  <= 1'b0;
    end else begin
      count_q   <= count_d;
      addr_q    <= addr_d;
      full_n_q  <= full_n_d;
      empty_n_q <= empty_n_d;
      afull_q   <= afull_d;
      err_ov_q  <= err_ov_d;
      err_un_q  <= err_un_d;
    end
  end

endmodule
